// File: rtl/spi_word_rx.sv
// SPI slave word receiver: synchronizes SCK/SSEL/MOSI into clk, assembles WIDTH-bit
// words and queues them in a first-word-fall-through FIFO. Define SPI_WORD_RX_FRAME_ERR_EN for frame_err.
module spi_word_rx #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SCK,
  input  logic                     SSEL,
  input  logic                     MOSI,
  output logic [WIDTH-1:0]         rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  logic [2:0]       sck_sync;
  logic [2:0]       ssel_sync;
  logic [1:0]       mosi_sync;
  logic             active_p0;
  logic             sample_p0;
  logic             abort_p0;
  logic             last_p0;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             ovf_evt;

  // Synchronizers: SCK/SSEL three flops, MOSI two flops; index 0 is the newest stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= {3{CPOL}};
      ssel_sync <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], SCK};
      ssel_sync <= {ssel_sync[1:0], SSEL};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  // Stage p0: edge / frame-boundary detection
  always_comb begin
    active_p0 = ~ssel_sync[1];
    if (SAMPLE_RISE) sample_p0 = active_p0 & sck_sync[1] & ~sck_sync[2];
    else             sample_p0 = active_p0 & ~sck_sync[1] & sck_sync[2];
    // SSEL just went inactive while a word was half assembled
    abort_p0  = ssel_sync[1] & ~ssel_sync[2] & (bit_cnt != '0);
    last_p0   = sample_p0 & (bit_cnt == LAST_BIT);
  end

  // Stage p1: bit assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      sreg    <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= last_p0;
      if (!active_p0)      bit_cnt <= '0;
      else if (last_p0)    bit_cnt <= '0;
      else if (sample_p0)  bit_cnt <= bit_cnt + CW'(1);
      if (abort_p0)        sreg <= '0;
      else if (sample_p0)  sreg <= shift_in(sreg, mosi_sync[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (last_p0) word_p1 <= shift_in(sreg, mosi_sync[1]);
  end

  // Stage p2: receive FIFO
  always_comb begin
    rx_valid = (count != '0);
    pop      = rx_valid & rx_ready;
    full     = (count == FULL_LEVEL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok  = vld_p1 & (~full | pop);
    ovf_evt  = vld_p1 & full & ~pop;
    rx_level = count;
    rx_data  = '0;
    if (rx_valid) rx_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (ovf_evt)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= word_p1;
  end

`ifdef SPI_WORD_RX_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= abort_p0;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_rx.sv
// Randomized bench for spi_word_rx: three configurations driven through their SPI pins and
// checked every cycle against a queue-based receive model plus directed literal checks.
module tb_spi_word_rx;

  localparam int H = 4;
  localparam int W  [3] = '{8, 12, 4};
  localparam int D  [3] = '{4, 4, 2};
  localparam int CP [3] = '{0, 1, 0};
  localparam int CH [3] = '{0, 1, 1};
  localparam int MF [3] = '{1, 0, 1};
`ifdef SPI_WORD_RX_FRAME_ERR_EN
  localparam int FERR_EXP = 1;
`else
  localparam int FERR_EXP = 0;
`endif

  typedef struct {
    int          d;
    int          c;
    logic [31:0] w;
  } ev_t;

  logic clk;
  logic rst;
  logic sck [3];
  logic ssel [3];
  logic mosi [3];
  logic rdy [3];
  logic clr [3];
  logic rdy_force [3];
  logic clr_force [3];
  logic rnd_rdy [3];
  logic rnd_clr [3];
  logic rand_mode;
  logic chk_en;

  logic [7:0]  data_a;
  logic [11:0] data_b;
  logic [3:0]  data_c;
  logic [2:0]  level_a, level_b;
  logic [1:0]  level_c;
  logic [31:0] dat [3];
  logic [4:0]  lvl [3];
  logic        vld [3];
  logic        ovf [3];
  logic        fer [3];

  int tests, fails, cyc;
  int cnt_m [3];
  int last_samp [3];
  int rise_cyc [3];
  int ferr_cnt [3];
  logic pv [3];
  ev_t push_ev [$];
  ev_t ferr_ev [$];

  logic [31:0] mf [3][16];
  int          mh [3];
  int          mn [3];
  logic        movf [3];
  logic        mferr [3];
  logic        pn [3];
  logic [31:0] pw [3];
  logic        fn [3];
  logic        pop_m, full_m, evt_m;
  logic [31:0] exp_d;

  spi_word_rx #(.WIDTH(8), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .SCK(sck[0]), .SSEL(ssel[0]), .MOSI(mosi[0]),
    .rx_data(data_a), .rx_valid(vld[0]), .rx_ready(rdy[0]), .rx_level(level_a),
    .overflow(ovf[0]), .ovf_clr(clr[0]), .frame_err(fer[0]));
  spi_word_rx #(.WIDTH(12), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .SCK(sck[1]), .SSEL(ssel[1]), .MOSI(mosi[1]),
    .rx_data(data_b), .rx_valid(vld[1]), .rx_ready(rdy[1]), .rx_level(level_b),
    .overflow(ovf[1]), .ovf_clr(clr[1]), .frame_err(fer[1]));
  spi_word_rx #(.WIDTH(4), .DEPTH(2), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .SCK(sck[2]), .SSEL(ssel[2]), .MOSI(mosi[2]),
    .rx_data(data_c), .rx_valid(vld[2]), .rx_ready(rdy[2]), .rx_level(level_c),
    .overflow(ovf[2]), .ovf_clr(clr[2]), .frame_err(fer[2]));

  assign dat[0] = {24'b0, data_a};
  assign dat[1] = {20'b0, data_b};
  assign dat[2] = {28'b0, data_c};
  assign lvl[0] = {2'b0, level_a};
  assign lvl[1] = {2'b0, level_b};
  assign lvl[2] = {3'b0, level_c};

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      rdy[d] = rand_mode ? rnd_rdy[d] : rdy_force[d];
      clr[d] = rand_mode ? rnd_clr[d] : clr_force[d];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference model: FIFO of words, updated on each rising clk edge
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      pn[d] = 1'b0; pw[d] = '0; fn[d] = 1'b0;
    end
    for (int i = 0; i < push_ev.size(); ) begin
      if (push_ev[i].c == cyc) begin
        pn[push_ev[i].d] = 1'b1; pw[push_ev[i].d] = push_ev[i].w; push_ev.delete(i);
      end else i++;
    end
    for (int i = 0; i < ferr_ev.size(); ) begin
      if (ferr_ev[i].c == cyc) begin
        fn[ferr_ev[i].d] = 1'b1; ferr_ev.delete(i);
      end else i++;
    end
    if (rst) begin
      push_ev.delete();
      ferr_ev.delete();
      for (int d = 0; d < 3; d++) begin
        mh[d] = 0; mn[d] = 0; movf[d] = 1'b0; mferr[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        pop_m  = rdy[d] && (mn[d] > 0);
        full_m = (mn[d] == D[d]);
        evt_m  = pn[d] && full_m && !pop_m;
        if (pop_m) begin mh[d] = (mh[d] + 1) % 16; mn[d]--; end
        if (pn[d] && !evt_m) begin mf[d][(mh[d] + mn[d]) % 16] = pw[d]; mn[d]++; end
        if (evt_m) movf[d] = 1'b1;
        else if (clr[d]) movf[d] = 1'b0;
        mferr[d] = fn[d];
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vld[d] && !pv[d]) rise_cyc[d] = cyc;
      pv[d] = vld[d];
      if (fer[d]) ferr_cnt[d]++;
      if (chk_en) begin
        exp_d = (mn[d] != 0) ? mf[d][mh[d]] : 32'd0;
        tests++;
        if (vld[d] !== (mn[d] != 0) || lvl[d] !== 5'(mn[d]) || dat[d] !== exp_d ||
            ovf[d] !== movf[d] || fer[d] !== mferr[d]) begin
          fails++;
          $display("FAIL model_cycle%0d_dut%0d: valid/level/ovf/ferr/data got %0b/%0d/%0b/%0b/%0h required %0b/%0d/%0b/%0b/%0h",
                   cyc, d, vld[d], lvl[d], ovf[d], fer[d], dat[d],
                   (mn[d] != 0), mn[d], movf[d], mferr[d], exp_d);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      rnd_rdy[d] = 1'($urandom_range(0, 1));
      rnd_clr[d] = ($urandom_range(0, 7) == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic hwait();
    repeat (H) @(negedge clk);
  endtask

  task automatic sampled(input int d, input logic [31:0] w);
    ev_t e;
    last_samp[d] = cyc;
    cnt_m[d]++;
    if (cnt_m[d] == W[d]) begin
      cnt_m[d] = 0;
      // pin edge -> two synchronizer clocks to detection -> two more to a visible word
      e.d = d; e.c = cyc + 4; e.w = w;
      push_ev.push_back(e);
    end
  endtask

  task automatic send_bits(input int d, input logic [31:0] val, input int n);
    logic [31:0] m;
    logic        b;
    m = (32'd1 << W[d]) - 32'd1;
    for (int i = 0; i < n; i++) begin
      b = (MF[d] != 0) ? val[W[d] - 1 - i] : val[i];
      if (CH[d] == 0) begin
        mosi[d] = b; hwait();
        sck[d] = ~sck[d]; sampled(d, val & m); hwait();
        sck[d] = ~sck[d];
      end else begin
        sck[d] = ~sck[d]; mosi[d] = b; hwait();
        sck[d] = ~sck[d]; sampled(d, val & m); hwait();
      end
    end
    if (CH[d] == 0) hwait();
  endtask

  task automatic begin_frame(input int d);
    ssel[d] = 1'b0;
    hwait();
  endtask

  task automatic end_frame(input int d);
    ev_t e;
    ssel[d] = 1'b1;
    if (FERR_EXP != 0 && cnt_m[d] != 0) begin
      e.d = d; e.c = cyc + 3; e.w = '0;
      ferr_ev.push_back(e);
    end
    cnt_m[d] = 0;
    hwait(); hwait();
  endtask

  task automatic pop_one(input int d);
    rdy_force[d] = 1'b1;
    @(negedge clk);
    rdy_force[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    rdy_force[d] = 1'b1;
    repeat (D[d] + 1) @(negedge clk);
    rdy_force[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) cnt_m[d] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop_at_push();
    int t;
    int target;
    t = 0;
    while (push_ev.size() == 0 && t < 2000) begin
      @(negedge clk); t++;
    end
    tests++;
    if (push_ev.size() == 0) begin
      fails++;
      $display("FAIL push_wait: no word scheduled after %0d cycles, required one", t);
    end else begin
      target = push_ev[0].c;
      while (cyc < target - 1) @(negedge clk);
      pop_one(0);
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; chk_en = 1'b0; rand_mode = 1'b0; rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      sck[d] = CP[d][0]; ssel[d] = 1'b1; mosi[d] = 1'b0;
      rdy_force[d] = 1'b0; clr_force[d] = 1'b0;
      cnt_m[d] = 0; rise_cyc[d] = -1; ferr_cnt[d] = 0; pv[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_valid%0d", d), 32'(vld[d]), 0);
      chk($sformatf("reset_data%0d", d), dat[d], 0);
      chk($sformatf("reset_level%0d", d), 32'(lvl[d]), 0);
      chk($sformatf("reset_ovf%0d", d), 32'(ovf[d]), 0);
    end

    // Mode 0 single word and its latency
    begin_frame(0); send_bits(0, 32'hA5, 8); end_frame(0);
    chk("a5_latency", 32'(rise_cyc[0] - last_samp[0]), 4);
    chk("a5_data", dat[0], 32'hA5);
    chk("a5_level", 32'(lvl[0]), 1);
    pop_one(0);
    chk("empty_data", dat[0], 0);
    chk("empty_level", 32'(lvl[0]), 0);
    pop_one(0);
    chk("pop_on_empty_level", 32'(lvl[0]), 0);

    // Mode 3, 12 bits, LSB first
    begin_frame(1); send_bits(1, 32'h123, 12); end_frame(1);
    chk("lsb12_data", dat[1], 32'h123);
    drain(1);

    // Overflow with five back-to-back words
    begin_frame(0);
    for (int k = 1; k <= 5; k++) send_bits(0, 32'(k), 8);
    end_frame(0);
    chk("ovf_level", 32'(lvl[0]), 4);
    chk("ovf_flag", 32'(ovf[0]), 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop%0d", k), dat[0], 32'(k));
      pop_one(0);
    end
    chk("ovf_sticky", 32'(ovf[0]), 1);
    clr_force[0] = 1'b1; @(negedge clk); clr_force[0] = 1'b0;
    chk("ovf_cleared", 32'(ovf[0]), 0);

    // Full FIFO: fifth push coincides with a pop
    begin_frame(0);
    for (int k = 0; k < 4; k++) send_bits(0, 32'h11 + 32'(k), 8);
    end_frame(0);
    begin_frame(0);
    fork
      send_bits(0, 32'h15, 8);
      pop_at_push();
    join
    end_frame(0);
    chk("simul_level", 32'(lvl[0]), 4);
    chk("simul_ovf", 32'(ovf[0]), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("simul_pop%0d", k), dat[0], 32'h12 + 32'(k));
      pop_one(0);
    end

    // Aborted frame after three bits, then a clean word
    ferr_cnt[0] = 0;
    begin_frame(0); send_bits(0, 32'hE0, 3); end_frame(0);
    chk("abort_ferr_pulses", 32'(ferr_cnt[0]), 32'(FERR_EXP));
    chk("abort_level", 32'(lvl[0]), 0);
    begin_frame(0); send_bits(0, 32'h3C, 8); end_frame(0);
    chk("after_abort_data", dat[0], 32'h3C);
    drain(0);

    // Mode 1, 4-bit words, depth 2
    begin_frame(2);
    send_bits(2, 32'h9, 4); send_bits(2, 32'h6, 4); send_bits(2, 32'hF, 4);
    end_frame(2);
    chk("c_level", 32'(lvl[2]), 2);
    chk("c_ovf", 32'(ovf[2]), 1);
    chk("c_head", dat[2], 32'h9);
    pop_one(2);
    chk("c_second", dat[2], 32'h6);

    // Reset in the middle of a word, with data and overflow pending
    begin_frame(0);
    send_bits(0, 32'h55, 8);
    send_bits(0, 32'hA8, 5);
    chk("pre_reset_level", 32'(lvl[0]), 1);
    do_reset();
    chk("rst_valid", 32'(vld[0]), 0);
    chk("rst_data", dat[0], 0);
    chk("rst_level", 32'(lvl[0]), 0);
    chk("rst_ovf_c", 32'(ovf[2]), 0);
    chk("rst_ferr", 32'(fer[0]), 0);
    send_bits(0, 32'h7E, 8);
    end_frame(0);
    chk("after_rst_data", dat[0], 32'h7E);
    chk("after_rst_level", 32'(lvl[0]), 1);
    drain(0);

    // Randomized frames with random consumer and clear activity
    rand_mode = 1'b1;
    for (int d = 0; d < 3; d++) begin
      for (int f = 0; f < 6; f++) begin
        begin_frame(d);
        for (int k = $urandom_range(1, 4); k > 0; k--) send_bits(d, $urandom, W[d]);
        if ($urandom_range(0, 3) == 0) send_bits(d, $urandom, $urandom_range(1, W[d] - 1));
        end_frame(d);
      end
    end
    rand_mode = 1'b0;
    for (int d = 0; d < 3; d++) rdy_force[d] = 1'b1;
    repeat (8) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      rdy_force[d] = 1'b0;
      chk($sformatf("final_level%0d", d), 32'(lvl[d]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
